// File: rtl/sseg_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus (an/sseg).
// Define SSEG_SCAN_ORDER_EN to add the scan_err digit-order checker.
module sseg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] an,
    input  logic [6:0] sseg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] blank,
    output logic [3:0] err,
    output logic       frame_tick,
    output logic       frame_valid,
`ifdef SSEG_SCAN_ORDER_EN
    output logic       scan_err,
`endif
    output logic [1:0] o_dbg_state,
    output logic [3:0] o_dbg_seen
);

    localparam int              TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    logic [3:0]       r_an_m, r_an_s, r_an_p;
    logic [6:0]       r_sseg_m, r_sseg_s, r_sseg_p;
    state_t           r_state, w_state_nxt;
    logic [7:0]       r_settle_cnt, w_cnt_nxt;
    logic [3:0][3:0]  r_hex;
    logic [3:0]       r_blank, r_err, r_seen;
    logic             r_frame_tick, r_frame_valid;
    logic [TO_W-1:0]  r_to_cnt;

    logic             w_legal, w_change, w_capture, w_timeout;
    logic [1:0]       w_idx;
    logic [3:0]       w_onehot;
    logic [3:0]       w_dec_val;
    logic             w_dec_hit, w_dec_blank;

    // Two-stage synchroniser plus a compare stage holding the previous sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_m   <= 4'hF;
            r_an_s   <= 4'hF;
            r_an_p   <= 4'hF;
            r_sseg_m <= 7'h7F;
            r_sseg_s <= 7'h7F;
            r_sseg_p <= 7'h7F;
        end else begin
            r_an_m   <= an;
            r_an_s   <= r_an_m;
            r_an_p   <= r_an_s;
            r_sseg_m <= sseg;
            r_sseg_s <= r_sseg_m;
            r_sseg_p <= r_sseg_s;
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (r_an_s)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_change = (r_an_s != r_an_p) || (r_sseg_s != r_sseg_p);
    assign w_onehot = 4'b0001 << w_idx;

    always_comb begin
        w_dec_val = 4'h0;
        w_dec_hit = 1'b1;
        case (r_sseg_s)
            7'b1000000: w_dec_val = 4'h0;
            7'b1111001: w_dec_val = 4'h1;
            7'b0100100: w_dec_val = 4'h2;
            7'b0110000: w_dec_val = 4'h3;
            7'b0011001: w_dec_val = 4'h4;
            7'b0010010: w_dec_val = 4'h5;
            7'b0000010: w_dec_val = 4'h6;
            7'b1111000: w_dec_val = 4'h7;
            7'b0000000: w_dec_val = 4'h8;
            7'b0010000: w_dec_val = 4'h9;
            7'b0001000: w_dec_val = 4'hA;
            7'b0000011: w_dec_val = 4'hB;
            7'b1000110: w_dec_val = 4'hC;
            7'b0100001: w_dec_val = 4'hD;
            7'b0000110: w_dec_val = 4'hE;
            7'b0001110: w_dec_val = 4'hF;
            default:    w_dec_hit = 1'b0;
        endcase
    end

    assign w_dec_blank = (r_sseg_s == 7'h7F);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_settle_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_legal) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_SETTLE: begin
                if (w_change) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = w_legal ? S_SETTLE : S_WAIT;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_HELD;
                end else begin
                    w_cnt_nxt   = r_settle_cnt + 8'd1;
                end
            end
            S_HELD: begin
                if (w_change) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = w_legal ? S_SETTLE : S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_WAIT;
            r_settle_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_cnt_nxt;
        end
    end

    // Unknown patterns keep the old value so a corrupt glyph never overwrites good data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex   <= '0;
            r_blank <= 4'hF;
            r_err   <= 4'h0;
        end else if (w_capture) begin
            if (w_dec_hit) begin
                r_hex[w_idx]   <= w_dec_val;
                r_blank[w_idx] <= 1'b0;
                r_err[w_idx]   <= 1'b0;
            end else if (w_dec_blank) begin
                r_hex[w_idx]   <= 4'h0;
                r_blank[w_idx] <= 1'b1;
                r_err[w_idx]   <= 1'b0;
            end else begin
                r_blank[w_idx] <= 1'b0;
                r_err[w_idx]   <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_to_cnt >= TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seen        <= 4'h0;
            r_frame_tick  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_frame_tick <= 1'b0;
            if (r_seen == 4'hF) begin
                r_frame_tick  <= 1'b1;
                r_frame_valid <= 1'b1;
                r_seen        <= w_capture ? w_onehot : 4'h0;
            end else if (w_capture) begin
                r_seen <= r_seen | w_onehot;
            end else if (w_timeout) begin
                r_seen        <= 4'h0;
                r_frame_valid <= 1'b0;
            end
            if (w_capture) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

`ifdef SSEG_SCAN_ORDER_EN
    logic [1:0] r_last_idx;
    logic       r_scan_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_idx <= 2'd3;
            r_scan_err <= 1'b0;
        end else begin
            r_scan_err <= w_capture && (w_idx != (r_last_idx + 2'd1));
            if (w_capture) begin
                r_last_idx <= w_idx;
            end
        end
    end

    assign scan_err = r_scan_err;
`endif

    assign hex0        = r_hex[0];
    assign hex1        = r_hex[1];
    assign hex2        = r_hex[2];
    assign hex3        = r_hex[3];
    assign blank       = r_blank;
    assign err         = r_err;
    assign frame_tick  = r_frame_tick;
    assign frame_valid = r_frame_valid;
    assign o_dbg_state = r_state;
    assign o_dbg_seen  = r_seen;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed frames, a glyph table, corner sequences
// and randomized bus traffic compared against a run-length reference model.
module tb_sseg_scan_decoder;

    localparam int S = 16;
    localparam int T = 300;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] an = 4'hF;
    logic [6:0] sseg = 7'h7F;
    logic [3:0] hex3, hex2, hex1, hex0, blank, err, o_dbg_seen;
    logic       frame_tick, frame_valid;
    logic [1:0] o_dbg_state;
`ifdef SSEG_SCAN_ORDER_EN
    logic       scan_err;
`endif

    sseg_scan_decoder #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .an         (an),
        .sseg       (sseg),
        .hex3       (hex3),
        .hex2       (hex2),
        .hex1       (hex1),
        .hex0       (hex0),
        .blank      (blank),
        .err        (err),
        .frame_tick (frame_tick),
        .frame_valid(frame_valid),
`ifdef SSEG_SCAN_ORDER_EN
        .scan_err   (scan_err),
`endif
        .o_dbg_state(o_dbg_state),
        .o_dbg_seen (o_dbg_seen)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- monitor (samples 1 time unit after each rising edge) ----------------
    int         cyc = 0;
    int         tick_cnt = 0, tick_cyc = -1, vfall_cyc = -1;
    int         hex8_cnt = 0, held_cnt = 0, serr_cnt = 0, serr_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [1:0] prev_state = 2'd0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (frame_tick) begin
            tick_cnt = tick_cnt + 1;
            tick_cyc = cyc;
        end
        if (prev_valid && !frame_valid) vfall_cyc = cyc;
        prev_valid = frame_valid;
        if (hex0 == 4'h8) hex8_cnt = hex8_cnt + 1;
        if (o_dbg_state == 2'd2 && prev_state != 2'd2) held_cnt = held_cnt + 1;
        prev_state = o_dbg_state;
`ifdef SSEG_SCAN_ORDER_EN
        if (scan_err) begin
            serr_cnt = serr_cnt + 1;
            serr_cyc = cyc;
        end
`endif
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] hex_of(input int idx);
        logic [15:0] all;
        all = {hex3, hex2, hex1, hex0};
        return all[idx*4 +: 4];
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " hex"}, {hex3, hex2, hex1, hex0}, 16'h0000);
        check({tag, " blank"}, blank, 4'hF);
        check({tag, " err"}, err, 4'h0);
        check({tag, " tick"}, frame_tick, 1'b0);
        check({tag, " valid"}, frame_valid, 1'b0);
        check({tag, " state"}, o_dbg_state, 2'd0);
        check({tag, " seen"}, o_dbg_seen, 4'h0);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; the first rising edge afterwards samples the new bus value.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a;
        sseg = s;
        repeat (n) @(negedge clk);
    endtask

    logic [6:0] glyph [16];

    // ---------------- reference model ----------------
    logic [10:0] pins[$];
    logic [3:0]  m_hex [4];
    logic [3:0]  m_blank, m_err, m_seen;
    logic        m_valid;
    int          m_ticks, m_serr;

    // Walks maximal runs of constant bus value: a legal run of at least S+1 samples
    // is captured at edge start+S+2; T edges without a capture drop the frame.
    task automatic model_round(input int n);
        int t, st, len, c, ref_edge, idx, last, found;
        logic [3:0] a;
        logic [6:0] s;
        for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
        m_blank = 4'hF; m_err = 4'h0; m_seen = 4'h0; m_valid = 1'b0;
        m_ticks = 0; m_serr = 0; last = 3; ref_edge = -1;
        t = 0;
        while (t < n) begin
            st = t;
            while (t < n && pins[t] == pins[st]) t++;
            len = t - st;
            a = pins[st][10:7];
            s = pins[st][6:0];
            if ($countones(~a) == 1 && len >= S + 1) begin
                c = st + S + 2;
                if (c >= ref_edge + T + 1) begin
                    m_valid = 1'b0;
                    m_seen = 4'h0;
                end
                idx = 0;
                for (int k = 0; k < 4; k++) if (!a[k]) idx = k;
                found = -1;
                for (int j = 0; j < 16; j++) if (glyph[j] == s) found = j;
                if (found >= 0) begin
                    m_hex[idx] = 4'(found); m_blank[idx] = 1'b0; m_err[idx] = 1'b0;
                end else if (s == 7'h7F) begin
                    m_hex[idx] = 4'h0; m_blank[idx] = 1'b1; m_err[idx] = 1'b0;
                end else begin
                    m_blank[idx] = 1'b0; m_err[idx] = 1'b1;
                end
                if (idx != (last + 1) % 4) m_serr++;
                last = idx;
                m_seen[idx] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_ticks++;
                    m_valid = 1'b1;
                    m_seen = 4'h0;
                end
                ref_edge = c;
            end
        end
        if (n - 1 >= ref_edge + T) begin
            m_valid = 1'b0;
            m_seen = 4'h0;
        end
    endtask

    task automatic random_round(input int r);
        int len, k, t0, s0, n;
        logic [3:0] a, one;
        logic [6:0] s;
        one = 4'b0001;
        pins.delete();
        while (pins.size() < 1200) begin
            if ($urandom_range(0, 99) < 5) begin
                a = 4'hF;
                len = T + 20;
            end else begin
                if ($urandom_range(0, 9) < 8) begin
                    a = ~(one << $urandom_range(0, 3));
                end else begin
                    a = 4'($urandom_range(0, 15));
                    while ($countones(~a) == 1) a = 4'($urandom_range(0, 15));
                end
                len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, S) : $urandom_range(S + 1, 45);
            end
            k = $urandom_range(0, 19);
            if (k < 12)      s = glyph[$urandom_range(0, 15)];
            else if (k < 15) s = 7'h7F;
            else             s = 7'($urandom_range(0, 127));
            repeat (len) pins.push_back({a, s});
        end
        repeat (60) pins.push_back({4'hF, 7'h7F});
        n = pins.size();
        model_round(n);

        reset_n = 1'b0;
        @(negedge clk);
        t0 = tick_cnt;
        s0 = serr_cnt;
        reset_n = 1'b1;
        for (int t = 0; t < n; t++) begin
            an = pins[t][10:7];
            sseg = pins[t][6:0];
            @(negedge clk);
        end
        check($sformatf("rand%0d hex0", r), hex0, m_hex[0]);
        check($sformatf("rand%0d hex1", r), hex1, m_hex[1]);
        check($sformatf("rand%0d hex2", r), hex2, m_hex[2]);
        check($sformatf("rand%0d hex3", r), hex3, m_hex[3]);
        check($sformatf("rand%0d blank", r), blank, m_blank);
        check($sformatf("rand%0d err", r), err, m_err);
        check($sformatf("rand%0d seen", r), o_dbg_seen, m_seen);
        check($sformatf("rand%0d valid", r), frame_valid, m_valid);
        check($sformatf("rand%0d ticks", r), tick_cnt - t0, m_ticks);
`ifdef SSEG_SCAN_ORDER_EN
        check($sformatf("rand%0d scan_err", r), serr_cnt - s0, m_serr);
`else
        if (s0 != serr_cnt) check($sformatf("rand%0d serr", r), serr_cnt, s0);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] an;
        logic [6:0] sseg;
        int         idx;
        logic [3:0] exp_hex;
        logic       exp_blank;
        logic       exp_err;
    } vec_t;

    vec_t tv [20];

    initial begin
        int c3, t0, h0, k0, s0;
        logic [3:0] one;
        one = 4'b0001;
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int i = 0; i < 16; i++)
            tv[i] = '{~(one << (i % 4)), glyph[i], i % 4, 4'(i), 1'b0, 1'b0};
        tv[16] = '{4'b1101, 7'b1111111, 1, 4'h0, 1'b1, 1'b0};
        tv[17] = '{4'b1011, 7'b1110111, 2, 4'hE, 1'b0, 1'b1};
        tv[18] = '{4'b1011, glyph[5],   2, 4'h5, 1'b0, 1'b0};
        tv[19] = '{4'b1110, 7'b0000001, 0, 4'hC, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Frame decode
        t0 = tick_cnt;
        hold(4'b1110, 7'b0110000, 40);
        hold(4'b1101, 7'b0100100, 40);
        hold(4'b1011, 7'b1111001, 40);
        c3 = cyc;
        hold(4'b0111, 7'b1000000, 40);
        check("frame hex0", hex0, 4'h3);
        check("frame hex1", hex1, 4'h2);
        check("frame hex2", hex2, 4'h1);
        check("frame hex3", hex3, 4'h0);
        check("frame blank", blank, 4'h0);
        check("frame err", err, 4'h0);
        check("frame tick count", tick_cnt - t0, 1);
        check("frame tick cycle", tick_cyc, c3 + S + 4);
        check("frame valid", frame_valid, 1'b1);

        // Glitch rejection
        h0 = hex8_cnt;
        k0 = held_cnt;
        hold(4'b1110, 7'b0000000, 10);
        hold(4'b1110, 7'b0010000, 40);
        check("glitch hex0", hex0, 4'h9);
        check("glitch never 8", hex8_cnt - h0, 0);
        check("glitch captures", held_cnt - k0, 1);
        check("glitch seen", o_dbg_seen, 4'b0001);

        // Settle boundary: S samples do not capture, S+1 samples do
        k0 = held_cnt;
        hold(4'b1101, 7'b0001000, S);
        hold(4'hF, 7'h7F, 30);
        check("boundary S hex1", hex1, 4'h2);
        check("boundary S captures", held_cnt - k0, 0);
        hold(4'b1101, 7'b0001000, S + 1);
        hold(4'hF, 7'h7F, 10);
        check("boundary S+1 hex1", hex1, 4'hA);
        check("boundary S+1 seen", o_dbg_seen, 4'b0011);

        // Illegal anodes
        k0 = held_cnt;
        hold(4'b1100, 7'b0000000, 100);
        check("illegal 1100 state", o_dbg_state, 2'd0);
        hold(4'b1111, 7'b0000000, 100);
        check("illegal 1111 state", o_dbg_state, 2'd0);
        check("illegal captures", held_cnt - k0, 0);
        check("illegal seen", o_dbg_seen, 4'b0011);
        check("illegal hex", {hex3, hex2, hex1, hex0}, 16'h01A9);

        // Glyph table, blank and illegal patterns
        for (int i = 0; i < 20; i++) begin
            hold(tv[i].an, tv[i].sseg, 40);
            check($sformatf("tv%0d hex", i), hex_of(tv[i].idx), tv[i].exp_hex);
            check($sformatf("tv%0d blank", i), blank[tv[i].idx], tv[i].exp_blank);
            check($sformatf("tv%0d err", i), err[tv[i].idx], tv[i].exp_err);
        end

        // Timeout after a valid frame
        hold(4'b1110, glyph[7], 40);
        hold(4'b1101, glyph[6], 40);
        hold(4'b1011, glyph[5], 40);
        c3 = cyc;
        hold(4'b0111, glyph[4], 40);
        check("timeout valid before", frame_valid, 1'b1);
        hold(4'hF, 7'h7F, T + 40);
        check("timeout valid after", frame_valid, 1'b0);
        check("timeout fall cycle", vfall_cyc, c3 + S + 3 + T);
        check("timeout hex held", {hex3, hex2, hex1, hex0}, 16'h4567);
        check("timeout seen", o_dbg_seen, 4'h0);

        // Asynchronous reset in the middle of settling
        hold(4'b1110, glyph[2], 8);
        check("midsettle state", o_dbg_state, 2'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async reset");
        @(negedge clk);
        an = 4'hF;
        sseg = 7'h7F;
        reset_n = 1'b1;
        @(negedge clk);

`ifdef SSEG_SCAN_ORDER_EN
        // Scan order: 0,1,3 flags only the digit-3 capture
        s0 = serr_cnt;
        hold(4'b1110, glyph[1], 40);
        hold(4'b1101, glyph[2], 40);
        c3 = cyc;
        hold(4'b0111, glyph[3], 40);
        hold(4'hF, 7'h7F, 10);
        check("order scan_err count", serr_cnt - s0, 1);
        check("order scan_err cycle", serr_cyc, c3 + S + 3);
`endif

        // Randomized traffic against the reference model
        for (int r = 0; r < 3; r++) random_round(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
